// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared types and constants for the fetch sequencer.
//   fetch_state_e  : sequencer FSM states (IDLE, REQ, WAIT, HOLD)
//   redirect_src_e : which redirect source won arbitration this cycle
//   DEF_RESET_PC   : default fetch address after reset
//   DEF_EXC_VECTOR : default exception handler entry address
package fetch_pkg;

  localparam logic [31:0] DEF_RESET_PC   = 32'h0000_1000;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_2000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    RD_NONE    = 2'd0,
    RD_EXC     = 2'd1,
    RD_IRET    = 2'd2,
    RD_MISPRED = 2'd3
  } redirect_src_e;

  // Instruction fetch is word aligned, so redirect targets drop their low bits.
  function automatic logic [31:0] alignWord(input logic [31:0] addr);
    return addr & ~32'h0000_0003;
  endfunction

endpackage

// File: rtl/fetch_seq_ctrl_redirect_arb.sv
// redirect_arb
// Combinational priority select between the three redirect requesters.
// Ports:
//   exc_i, iret_i, mispred_i : redirect requests (exc highest, mispred lowest)
//   iret_pc_i, mispred_pc_i  : requested targets
//   valid_o                  : some redirect is active this cycle
//   src_o                    : winning source (RD_NONE when idle)
//   target_o                 : winning target, word aligned
module redirect_arb
  import fetch_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic          exc_i,
  input  logic          iret_i,
  input  logic [31:0]   iret_pc_i,
  input  logic          mispred_i,
  input  logic [31:0]   mispred_pc_i,
  output logic          valid_o,
  output redirect_src_e src_o,
  output logic [31:0]   target_o
);

  // Fixed priority: an exception overrides an iret, which overrides a
  // mispredict. The target is aligned here so the sequencer never sees an
  // unaligned fetch address.
  always_comb begin
    valid_o  = 1'b0;
    src_o    = RD_NONE;
    target_o = 32'h0;
    if (exc_i) begin
      valid_o  = 1'b1;
      src_o    = RD_EXC;
      target_o = alignWord(EXC_VECTOR);
    end else if (iret_i) begin
      valid_o  = 1'b1;
      src_o    = RD_IRET;
      target_o = alignWord(iret_pc_i);
    end else if (mispred_i) begin
      valid_o  = 1'b1;
      src_o    = RD_MISPRED;
      target_o = alignWord(mispred_pc_i);
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// fetch_seq_ctrl
// Fetch sequencer: owns the fetch PC, issues one icache request at a time,
// applies redirects, discards responses made stale by a redirect and holds
// the fetched instruction while decode is stalled. All outputs are registered.
// Ports:
//   clk_i, rst_i                  : clock, async active-high reset
//   stall_i                       : decode cannot accept this cycle
//   exc_i / iret_i / mispred_i    : redirect requests (+ iret_pc_i, mispred_pc_i)
//   pred_taken_i, pred_pc_i       : predictor result for inst_pc_o
//   ic_req_o, ic_addr_o, ic_gnt_i : icache request handshake
//   ic_rvalid_i, ic_rdata_i       : icache response
//   inst_valid_o, inst_o, inst_pc_o : instruction to decode
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter logic [31:0] EXC_VECTOR = DEF_EXC_VECTOR
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        exc_i,
  input  logic        iret_i,
  input  logic [31:0] iret_pc_i,
  input  logic        mispred_i,
  input  logic [31:0] mispred_pc_i,
  input  logic        pred_taken_i,
  input  logic [31:0] pred_pc_i,
  output logic        ic_req_o,
  output logic [31:0] ic_addr_o,
  input  logic        ic_gnt_i,
  input  logic        ic_rvalid_i,
  input  logic [31:0] ic_rdata_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_pc_o
);

  fetch_state_e  state_q, state_d;
  logic [31:0]   fetchPc_q, fetchPc_d;
  logic          kill_q, kill_d;
  logic          icReq_q, icReq_d;
  logic [31:0]   icAddr_q, icAddr_d;
  logic          instValid_q, instValid_d;
  logic [31:0]   inst_q, inst_d;
  logic [31:0]   instPc_q, instPc_d;

  logic          rdValid;
  redirect_src_e rdSrc;
  logic [31:0]   rdTarget;
  logic          redirect;

  redirect_arb #(
    .EXC_VECTOR (EXC_VECTOR)
  ) u_redirect_arb (
    .exc_i        (exc_i),
    .iret_i       (iret_i),
    .iret_pc_i    (iret_pc_i),
    .mispred_i    (mispred_i),
    .mispred_pc_i (mispred_pc_i),
    .valid_o      (rdValid),
    .src_o        (rdSrc),
    .target_o     (rdTarget)
  );

  // Both arbiter outputs are consulted so that a valid bit without a winning
  // source (or the reverse) can never move the fetch PC on its own.
  assign redirect = rdValid && (rdSrc != RD_NONE);

  // Next-state logic. The request/valid outputs are derived from the next
  // state so they appear registered exactly one cycle after the event that
  // caused them (redirect, grant, response or accept).
  always_comb begin
    state_d   = state_q;
    fetchPc_d = fetchPc_q;
    kill_d    = kill_q;
    inst_d    = inst_q;
    instPc_d  = instPc_q;

    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_REQ;
      end
      ST_REQ: begin
        if (ic_gnt_i) begin
          state_d = ST_WAIT;
          // The icache already latched the old address, so its response is stale.
          if (redirect) kill_d = 1'b1;
        end
      end
      ST_WAIT: begin
        if (ic_rvalid_i) begin
          if (kill_q || redirect) begin
            kill_d  = 1'b0;
            state_d = ST_REQ;
          end else begin
            inst_d   = ic_rdata_i;
            instPc_d = fetchPc_q;
            state_d  = ST_HOLD;
          end
        end else if (redirect) begin
          kill_d = 1'b1;
        end
      end
      ST_HOLD: begin
        if (redirect) begin
          state_d = ST_REQ;
        end else if (!stall_i) begin
          fetchPc_d = pred_taken_i ? pred_pc_i : fetchPc_q + 32'd4;
          state_d   = ST_REQ;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A redirect loads the fetch PC whatever state the sequencer is in.
    if (redirect) fetchPc_d = rdTarget;

    icReq_d     = (state_d == ST_REQ);
    icAddr_d    = fetchPc_d;
    instValid_d = (state_d == ST_HOLD);
  end

  // State and output registers; reset parks the sequencer in IDLE at the
  // reset PC with nothing requested and nothing presented to decode.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      fetchPc_q   <= RESET_PC;
      kill_q      <= 1'b0;
      icReq_q     <= 1'b0;
      icAddr_q    <= RESET_PC;
      instValid_q <= 1'b0;
      inst_q      <= 32'h0;
      instPc_q    <= 32'h0;
    end else begin
      state_q     <= state_d;
      fetchPc_q   <= fetchPc_d;
      kill_q      <= kill_d;
      icReq_q     <= icReq_d;
      icAddr_q    <= icAddr_d;
      instValid_q <= instValid_d;
      inst_q      <= inst_d;
      instPc_q    <= instPc_d;
    end
  end

  assign ic_req_o     = icReq_q;
  assign ic_addr_o    = icAddr_q;
  assign inst_valid_o = instValid_q;
  assign inst_o       = inst_q;
  assign inst_pc_o    = instPc_q;

endmodule

// File: doc/fetch_seq_ctrl.md
# fetch_seq_ctrl

Fetch sequencer between the PC/branch-predictor logic and the instruction cache. It owns the fetch PC, issues one instruction-cache request at a time over a request/grant handshake, and arbitrates redirects from exceptions, interrupt return and branch mispredicts. It also discards responses that a redirect has made stale, and holds the fetched instruction while the core stalls. Decode consumes its inst_* outputs.

## Interface
- RESET_PC, 32'h1000, fetch address after reset
- EXC_VECTOR, 32'h2000, exception handler entry address
- clk_i  in  1  core clock
- rst_i  in  1  asynchronous, active-high reset
- stall_i  in  1  core stall; decode cannot accept this cycle
- exc_i  in  1  exception redirect request
- iret_i  in  1  interrupt-return redirect request
- iret_pc_i  in  32  iret target
- mispred_i  in  1  branch mispredict redirect request
- mispred_pc_i  in  32  corrected target
- pred_taken_i  in  1  predictor says taken for inst_pc_o
- pred_pc_i  in  32  predicted target for inst_pc_o
- ic_req_o  out  1  icache request valid
- ic_addr_o  out  32  icache request address
- ic_gnt_i  in  1  icache accepted request this cycle
- ic_rvalid_i  in  1  icache response valid
- ic_rdata_i  in  32  icache response data
- inst_valid_o  out  1  instruction valid to decode
- inst_o  out  32  instruction word
- inst_pc_o  out  32  PC of inst_o

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
- Reset: state=IDLE, fetch_pc=RESET_PC, kill=0, ic_req_o=0, inst_valid_o=0, inst_o=0, inst_pc_o=0, ic_addr_o=RESET_PC.
- IDLE: always goes to REQ on the next cycle.
- REQ: ic_req_o=1, ic_addr_o=fetch_pc. On ic_gnt_i, go to WAIT.
- WAIT: on ic_rvalid_i with kill=0, latch inst_o=ic_rdata_i and inst_pc_o=fetch_pc, assert inst_valid_o, and go to HOLD.
- WAIT, killed response: on ic_rvalid_i with kill=1, drop the data, clear kill and go to REQ.
- HOLD: inst_valid_o=1 while stall_i=1; outputs stay stable.
- HOLD accept: on stall_i=0, the instruction is accepted. Set fetch_pc = pred_taken_i ? pred_pc_i : fetch_pc+4, deassert inst_valid_o and go to REQ.
- Redirect priority: exc_i > iret_i > mispred_i. The target is EXC_VECTOR, iret_pc_i or mispred_pc_i; bits [1:0] are forced to 0. The winner loads fetch_pc in any state.
- Redirect in REQ: ic_addr_o changes to the target on the next cycle. The icache samples the address only on grant.
- Redirect in REQ with ic_gnt_i in the same cycle: set kill=1, go to WAIT.
- Redirect in WAIT: set kill=1, unless ic_rvalid_i is high in the same cycle. In that case drop the response and go to REQ.
- Redirect in HOLD: deassert inst_valid_o, go to REQ. This takes priority over stall_i.
- Redirect in IDLE: go to REQ with the target.
- At most one request outstanding; kill is 1 bit.
- Arithmetic: fetch_pc+4 wraps modulo 2^32.

## Timing
- All outputs are registered.
- Redirect sampled at cycle N: ic_req_o=1 with the target at N+1 (N+1 is also the earliest case).
- ic_gnt_i at N: ic_req_o=0 at N+1.
- ic_rvalid_i at M: inst_valid_o=1 at M+1.
- Accept at cycle A (HOLD, stall_i=0): next ic_req_o=1 at A+1.
- Best-case throughput: one instruction per 3 cycles with 1-cycle icache latency.
- Reset deasserting mid-transaction: a response from before reset is ignored, because the FSM is in IDLE and only WAIT samples ic_rvalid_i.

## Structure
- Shared fetch_pkg: FSM state enum, RESET_PC/EXC_VECTOR defaults, redirect source encoding (NONE, EXC, IRET, MISPRED).
- Sub-module redirect_arb: combinational priority select. Outputs a redirect valid bit, the source and the aligned target.

## Test plan
- Reset release with 1-cycle grant and 1-cycle response: ic_addr_o=0x1000, then 0x1004 after accept; inst_pc_o matches each address.
- pred_taken_i=1, pred_pc_i=0x1400 on accept of 0x1000: next ic_addr_o=0x1400.
- Stall held 5 cycles in HOLD: inst_valid_o, inst_o and inst_pc_o stay stable; no ic_req_o.
- mispred_i (target 0x2200) in WAIT: the stale rvalid is dropped and never reaches inst_valid_o; next ic_addr_o=0x2200.
- exc_i, iret_i and mispred_i in the same cycle: next ic_addr_o=0x2000. iret_pc_i=0x1233 alone gives ic_addr_o=0x1230.
- Redirect in the same cycle as ic_gnt_i: kill is set, the response is discarded, then a request goes out to the target.
